// File: rtl/mdu_pkg.sv
// Shared definitions for the EXE-stage multiply/divide controller:
// operation codes, controller state encoding and default widths.
package mdu_pkg;

  // Default widths: operands/HI/LO and the divide busy-cycle counter.
  localparam int unsigned MDU_DATA_W = 32;
  localparam int unsigned MDU_CNT_W  = 6;

  // Operation codes presented by EXE; codes 6 and 7 are unused.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  // Controller states. SEND holds the operand handshake, WAIT waits for
  // a live result, DRAIN swallows the result of an abandoned divide.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } mdu_state_e;

  // Divider result layout: quotient in the upper half of tdata,
  // remainder in the lower half.
  localparam int unsigned MDU_DOUT_QUOT_HALF = 1;
  localparam int unsigned MDU_DOUT_REM_HALF  = 0;

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, completes multiplies and HI/LO
// moves in one cycle, and sequences the signed/unsigned AXI-stream divider
// IPs. A cancelled divide is drained from its IP and its result dropped.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W,
  parameter int unsigned CNT_W  = MDU_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic [2:0]          op_code,
  input  logic [DATA_W-1:0]   op_src1,
  input  logic [DATA_W-1:0]   op_src2,
  input  logic                flush,
  output logic                op_done,
  output logic                busy,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [CNT_W-1:0]    div_cycles,
  output logic                sdiv_in_tvalid,
  input  logic                sdiv_in_tready,
  output logic                udiv_in_tvalid,
  input  logic                udiv_in_tready,
  output logic [DATA_W-1:0]   div_dividend,
  output logic [DATA_W-1:0]   div_divisor,
  input  logic                sdiv_out_tvalid,
  input  logic [2*DATA_W-1:0] sdiv_out_tdata,
  input  logic                udiv_out_tvalid,
  input  logic [2*DATA_W-1:0] udiv_out_tdata
);

  mdu_state_e          state_q;
  logic                sel_signed_q;   // 1: div_mod selected, 0: divu_mod
  logic                killed_q;       // in-flight divide was flushed
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   dividend_q, divisor_q;
  logic [CNT_W-1:0]    cnt_q, div_cycles_q;
  logic [CNT_W-1:0]    cnt_d;

  logic                sel_in_tready;
  logic                sel_out_tvalid;
  logic [2*DATA_W-1:0] sel_out_tdata;
  logic                is_div_op;

  // Operands widened explicitly so the products carry the full 2*DATA_W bits.
  logic signed [2*DATA_W-1:0] src1_s, src2_s, prod_s;
  logic        [2*DATA_W-1:0] src1_u, src2_u, prod_u;

  assign src1_s = {{DATA_W{op_src1[DATA_W-1]}}, op_src1};
  assign src2_s = {{DATA_W{op_src2[DATA_W-1]}}, op_src2};
  assign src1_u = {{DATA_W{1'b0}}, op_src1};
  assign src2_u = {{DATA_W{1'b0}}, op_src2};
  assign prod_s = src1_s * src2_s;
  assign prod_u = src1_u * src2_u;

  // Only the IP chosen at issue is listened to; the other one is ignored.
  assign sel_in_tready  = sel_signed_q ? sdiv_in_tready  : udiv_in_tready;
  assign sel_out_tvalid = sel_signed_q ? sdiv_out_tvalid : udiv_out_tvalid;
  assign sel_out_tdata  = sel_signed_q ? sdiv_out_tdata  : udiv_out_tdata;

  assign is_div_op = (op_code == MDU_DIV) || (op_code == MDU_DIVU);

  // Busy-cycle counter saturates instead of wrapping.
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Completion strobe: single-cycle ops (and unknown codes) finish in IDLE,
  // a divide finishes when its live result arrives and is not being flushed.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    op_done = 1'b0;
    case (state_q)
      ST_IDLE: op_done = op_valid && !flush && !is_div_op;
      ST_WAIT: op_done = sel_out_tvalid && !killed_q && !flush;
      default: op_done = 1'b0;
    endcase
  end

  // Controller FSM together with HI/LO, operand latches and cycle counters.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_signed_q <= 1'b0;
      killed_q     <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      cnt_q        <= '0;
      div_cycles_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid && !flush) begin
            case (op_code)
              MDU_MULT:  {hi_q, lo_q} <= prod_s;
              MDU_MULTU: {hi_q, lo_q} <= prod_u;
              MDU_MTHI:  hi_q <= op_src1;
              MDU_MTLO:  lo_q <= op_src1;
              MDU_DIV, MDU_DIVU: begin
                dividend_q   <= op_src1;
                divisor_q    <= op_src2;
                sel_signed_q <= (op_code == MDU_DIV);
                killed_q     <= 1'b0;
                cnt_q        <= '0;
                state_q      <= ST_SEND;
              end
              default: ;  // unknown code: acknowledged, no effect
            endcase
          end
        end
        ST_SEND: begin
          // tvalid stays up until accepted even when flushed; a flushed
          // divide is then drained instead of waited on.
          cnt_q <= cnt_d;
          if (flush) killed_q <= 1'b1;
          if (sel_in_tready) state_q <= (killed_q || flush) ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (sel_out_tvalid) begin
            state_q <= ST_IDLE;
            if (!killed_q && !flush) begin
              lo_q         <= sel_out_tdata[MDU_DOUT_QUOT_HALF*DATA_W +: DATA_W];
              hi_q         <= sel_out_tdata[MDU_DOUT_REM_HALF*DATA_W +: DATA_W];
              div_cycles_q <= cnt_d;
            end
          end else begin
            cnt_q <= cnt_d;
            if (flush || killed_q) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (sel_out_tvalid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign div_cycles     = div_cycles_q;
  assign sdiv_in_tvalid = (state_q == ST_SEND) &&  sel_signed_q;
  assign udiv_in_tvalid = (state_q == ST_SEND) && !sel_signed_q;
  assign div_dividend   = dividend_q;
  assign div_divisor    = divisor_q;

endmodule
